// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller and its BCD conversion engine.
package fnd_pkg;

  localparam int DIGITS     = 4;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = 16;
  localparam int MAX_VALUE  = 9999;
  localparam int CONV_STEPS = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } fsm_state_t;

  // Values beyond four decimal digits saturate to the largest displayable number.
  function automatic logic [BIN_W-1:0] clamp_value(input logic [BIN_W-1:0] value);
    return (value > BIN_W'(MAX_VALUE)) ? BIN_W'(MAX_VALUE) : value;
  endfunction

  function automatic logic [3:0] nibble_add3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, CONV_STEPS steps per start.
// done is high during the cycle whose edge performs the final shift; bcd is valid the cycle after.
module fnd_bin2bcd
  import fnd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] bin_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_adj;
  logic [3:0]       cnt_reg;
  logic             busy_reg;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = nibble_add3(bcd_reg[gi*4 +: 4]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start && !busy_reg) begin
      bin_reg  <= bin;
      bcd_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
    end else if (busy_reg) begin
      {bcd_reg, bin_reg} <= {bcd_adj, bin_reg} << 1;
      cnt_reg            <= cnt_reg + 4'd1;
      if (cnt_reg == 4'(CONV_STEPS - 1)) busy_reg <= 1'b0;
    end
  end

  assign busy = busy_reg;
  assign done = busy_reg && (cnt_reg == 4'(CONV_STEPS - 1));
  assign bcd  = bcd_reg;

endmodule

// File: rtl/fnd_scan_controller.sv
// Load/convert/display sequencer and digit scanner for a 4-digit FND.
// Leading-zero blanking is built only when FND_LZ_BLANK_EN is defined.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [BIN_W-1:0] i_value,
  input  logic             i_load,
  output logic             o_busy,
  output logic [1:0]       o_digitSelect,
  output logic [3:0]       o_bcd,
  output logic             o_en
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  fsm_state_t       state_reg, state_next;
  logic             start, commit;
  logic             eng_busy, eng_done;
  logic [BCD_W-1:0] eng_bcd;
  logic [BCD_W-1:0] display_reg;
  logic [PW-1:0]    presc_reg;
  logic [1:0]       scan_idx_reg;

  fnd_bin2bcd u_bin2bcd (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .start (start),
    .bin   (clamp_value(i_value)),
    .busy  (eng_busy),
    .done  (eng_done),
    .bcd   (eng_bcd)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_reg <= IDLE;
    else            state_reg <= state_next;
  end

  // Leaving CONV on an idle engine is only a guard against an orphaned conversion.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_load) state_next = CONV;
      CONV:    if (eng_done || !eng_busy) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start  = 1'b0;
    commit = 1'b0;
    o_busy = 1'b1;
    case (state_reg)
      IDLE: begin
        o_busy = 1'b0;
        start  = i_load;
      end
      COMMIT:  commit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)  display_reg <= '0;
    else if (commit) display_reg <= eng_bcd;
  end

  // Scan timing free-runs regardless of conversion activity.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_reg    <= '0;
      scan_idx_reg <= '0;
    end else if (presc_reg == PW'(SCAN_DIV - 1)) begin
      presc_reg    <= '0;
      scan_idx_reg <= scan_idx_reg + 2'd1;
    end else begin
      presc_reg    <= presc_reg + PW'(1);
    end
  end

  assign o_digitSelect = scan_idx_reg;
  assign o_bcd         = display_reg[{scan_idx_reg, 2'b00} +: 4];

`ifdef FND_LZ_BLANK_EN
  logic [DIGITS-1:0] nz;
  logic [1:0]        msd;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nz
    assign nz[gi] = |display_reg[gi*4 +: 4];
  end

  // Position 0 is never blanked, so a zero display still shows one digit.
  always_comb begin
    msd = 2'd0;
    for (int i = 1; i < DIGITS; i++) begin
      if (nz[i]) msd = 2'(i);
    end
  end

  assign o_en = (scan_idx_reg <= msd);
`else
  assign o_en = 1'b1;
`endif

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized and directed bench for fnd_scan_controller against a decimal-arithmetic display model.
module tb_fnd_scan_controller;

  localparam int SCAN_DIV = 4;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [13:0] i_value = '0;
  logic        i_load = 1'b0;
  logic        o_busy;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_bcd;
  logic        o_en;

  int checks = 0;
  int failures = 0;

  // Model: edges since reset release, shown value, and the one pending load.
  int edge_cnt = 0;
  int disp = 0;
  int pending = 0;
  int commit_edge = 0;
  bit have_pending = 1'b0;
  int pow10[4] = '{1, 10, 100, 1000};

  always #5 i_clk = ~i_clk;

  fnd_scan_controller #(.SCAN_DIV(SCAN_DIV)) dut (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_value       (i_value),
    .i_load        (i_load),
    .o_busy        (o_busy),
    .o_digitSelect (o_digitSelect),
    .o_bcd         (o_bcd),
    .o_en          (o_en)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, expv, edge_cnt);
    end
  endtask

  task automatic check_outputs();
    int idx;
    int en_exp;
    idx = (edge_cnt / SCAN_DIV) % 4;
`ifdef FND_LZ_BLANK_EN
    en_exp = (idx == 0 || disp >= pow10[idx]) ? 1 : 0;
`else
    en_exp = 1;
`endif
    chk("busy", o_busy, int'(have_pending));
    chk("digit_select", o_digitSelect, idx);
    chk("bcd", o_bcd, (disp / pow10[idx]) % 10);
    chk("en", o_en, en_exp);
  endtask

  task automatic tick();
    int k;
    @(posedge i_clk);
    k = edge_cnt + 1;
    if (have_pending) begin
      if (k == commit_edge) begin
        disp = pending;
        have_pending = 1'b0;
        $display("commit: display=%0d at edge %0d", disp, k);
      end
    end else if (i_load) begin
      pending = (int'(i_value) > 9999) ? 9999 : int'(i_value);
      have_pending = 1'b1;
      commit_edge = k + 15;
      $display("load accepted: value=%0d shown_as=%0d at edge %0d", i_value, pending, k);
    end
    edge_cnt = k;
    #1 check_outputs();
  endtask

  task automatic step(input bit ld, input int val);
    i_value = 14'(val);
    i_load = ld;
    tick();
    i_load = 1'b0;
  endtask

  task automatic wait_idle_then_scan(input int scan_cycles);
    for (int i = 0; i < 40 && have_pending; i++) tick();
    chk("conversion_finished", o_busy, 0);
    repeat (scan_cycles) tick();
  endtask

  task automatic model_reset();
    edge_cnt = 0;
    disp = 0;
    have_pending = 1'b0;
  endtask

  initial begin
    // Reset state
    i_reset_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 check_outputs();
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Basic conversion and scan wrap
    step(1, 1234);
    wait_idle_then_scan(20);

    // Clamp above 9999
    step(1, 12000);
    wait_idle_then_scan(16);

    // Loads during CONV and at the COMMIT edge are dropped; the next edge accepts
    step(1, 5678);
    repeat (2) tick();
    step(1, 1111);
    repeat (11) tick();
    step(1, 1111);
    chk("display_after_commit", o_bcd, (5678 / pow10[(edge_cnt / SCAN_DIV) % 4]) % 10);
    step(1, 777);
    chk("load_at_cycle16_accepted", o_busy, 1);
    wait_idle_then_scan(16);

    // Old value held until COMMIT, then 9000 in one step
    step(1, 1);
    wait_idle_then_scan(4);
    step(1, 9000);
    wait_idle_then_scan(16);

    // Leading-zero cases
    step(1, 42);
    wait_idle_then_scan(16);
    step(1, 0);
    wait_idle_then_scan(16);

    // Random loads, including pulses while busy and out-of-range values
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(7) == 0), int'($urandom_range(16383)));
    end
    wait_idle_then_scan(8);

    // Reset during conversion
    step(1, 4321);
    repeat (7) tick();
    #2 i_reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
